device_lock_arbiter: RTL and testbench
======================================

# device_lock_arbiter

Bank of hardware mutexes on the cluster device bus with fair, queued hand-off between cores. Replaces first-to-poll mutex acquisition: a core that requests a held lock is recorded as a waiter, and on release ownership passes directly to the next waiter in round-robin core order. Sits beside the output port on the device bus, decoding its own address window and driving read data back to the cluster.

## Interface
- NUM_CORES, 16, number of requesting cores; core ids 0..NUM_CORES-1
- NUM_LOCKS, 4, number of independent locks (1..16)
- BASE_ADDR, 10'h3f0, device address of lock 0; lock i at BASE_ADDR+i
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- device_core_id  input  $clog2(NUM_CORES)  id of core issuing current access
- device_write_en  input  1  write strobe
- device_read_en  input  1  read strobe
- device_addr  input  10  device address
- device_data_out  input  16  write data from core
- device_data_in  output  16  registered read data to core
- lock_held  output  NUM_LOCKS  bit i = lock i currently owned (registered)

## Operation
- Per lock i: held (1b), holder (core id), pending (NUM_CORES-bit waiter mask).
- Hit: device_addr in [BASE_ADDR, BASE_ADDR+NUM_LOCKS); index = device_addr-BASE_ADDR. Non-hits change nothing, including device_data_in.
- Write with device_data_out != 0 (acquire):
  - not held: held<=1, holder<=core.
  - held by caller: no change.
  - held by another core: pending[core]<=1 (idempotent).
- Write with device_data_out == 0:
  - caller is holder, no waiters: held<=0.
  - caller is holder, waiters present: held stays 1; holder<=first set pending bit scanning core ids holder+1, holder+2, ... wrapping modulo NUM_CORES; that pending bit cleared, same edge.
  - caller not holder but pending: pending[core]<=0 (cancel).
  - otherwise ignored.
- Read: device_data_in <= {14'b0, pending[core], held && holder==core}. Software polls bit0 until set.
- device_write_en and device_read_en both high: treated as a write only; device_data_in unchanged.
- Holder never has its own pending bit set.
- Locks are independent; one bus access per cycle, so at most one lock changes per cycle.

## Timing
- Reset (asynchronous assert): held=0, holder=0, pending=0 for all locks; device_data_in=0; lock_held=0.
- Write at cycle N: lock state updated at edge ending N; a read at N+1 observes it.
- Read at cycle N: device_data_in valid in N+1, held until next hit read.
- Hand-off release->next owner: zero idle cycles; the lock is never observably free while waiters exist.
- Round-robin scan is combinational over NUM_CORES bits; single-cycle decision.
- Reset mid-operation: all ownership and queues discarded; cores must re-request.

## Test plan
- Core 3 writes 1 to lock 0, reads lock 0 -> device_data_in=16'h0001 next cycle; core 5 reads -> 16'h0000; lock_held=4'b0001.
- Core 3 holds lock 0; cores 7 and 1 write 1 -> core 7 read returns 16'h0002; core 3 writes 0 -> holder=7, lock_held[0] stays 1; core 7 writes 0 -> holder=1; core 1 writes 0 -> lock_held[0]=0.
- Wrap-around: core 14 holds, waiters 2 and 15 -> release grants 15, then 2.
- Core 9 (not holder, not pending) writes 0 to held lock -> no change; pending core 6 writes 0 -> read by core 6 returns 16'h0000 and release skips it.
- Simultaneous read+write strobes by holder with data 0 -> lock freed, device_data_in unchanged; access to BASE_ADDR+NUM_LOCKS -> no state change.
- Assert reset while lock 2 held with two waiters -> lock_held=0, device_data_in=0 immediately; first acquire after reset succeeds.

Source files
------------

// File: rtl/device_lock_arbiter_if.sv
// device_lock_arbiter_if: cluster device-bus signals between cores (master) and the lock bank (slave)
interface device_lock_arbiter_if #(
  parameter int NUM_CORES = 16
);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  logic [IW-1:0] device_core_id;
  logic          device_write_en;
  logic          device_read_en;
  logic [9:0]    device_addr;
  logic [15:0]   device_data_out;
  logic [15:0]   device_data_in;
  modport master (
    output device_core_id, device_write_en, device_read_en, device_addr, device_data_out,
    input  device_data_in
  );
  modport slave (
    input  device_core_id, device_write_en, device_read_en, device_addr, device_data_out,
    output device_data_in
  );
endinterface

// File: rtl/device_lock_arbiter.sv
// device_lock_arbiter: bank of bus-mapped mutexes with queued round-robin hand-off on release
module device_lock_arbiter #(
  parameter int         NUM_CORES = 16,
  parameter int         NUM_LOCKS = 4,
  parameter logic [9:0] BASE_ADDR = 10'h3f0
) (
  input  logic                 clk,
  input  logic                 reset,
  device_lock_arbiter_if.slave bus,
  output logic [NUM_LOCKS-1:0] lock_held
);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam int LW = NUM_LOCKS > 1 ? $clog2(NUM_LOCKS) : 1;
  logic [NUM_LOCKS-1:0] held_q, held_d;
  logic [IW-1:0]        holder_q [NUM_LOCKS];
  logic [IW-1:0]        holder_d [NUM_LOCKS];
  logic [NUM_CORES-1:0] pend_q [NUM_LOCKS];
  logic [NUM_CORES-1:0] pend_d [NUM_LOCKS];
  logic [15:0]          data_q, data_d;
  logic [9:0]           off;
  logic [LW-1:0]        sel;
  logic [IW-1:0]        core, nxt, cand;
  logic                 hit, wr, rd, mine, waiting, found;
  assign core      = bus.device_core_id;
  assign off       = bus.device_addr - BASE_ADDR;
  assign hit       = bus.device_addr >= BASE_ADDR && off < 10'(NUM_LOCKS);
  assign sel       = off[LW-1:0];
  assign wr        = hit && bus.device_write_en;
  assign rd        = hit && bus.device_read_en && !bus.device_write_en;
  assign mine      = held_q[sel] && holder_q[sel] == core;
  assign waiting   = pend_q[sel][core];
  assign lock_held = held_q;
  assign bus.device_data_in = data_q;
  // first waiter after the current holder, wrapping over core ids
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = IW'((int'(holder_q[sel]) + k) % NUM_CORES);
      if (!found && pend_q[sel][cand]) begin
        found = 1'b1;
        nxt   = cand;
      end
    end
  end
  always_comb begin
    held_d   = held_q;
    holder_d = holder_q;
    pend_d   = pend_q;
    data_d   = data_q;
    if (wr && bus.device_data_out != '0) begin
      if (!held_q[sel]) begin
        held_d[sel]   = 1'b1;
        holder_d[sel] = core;
      end else if (!mine) begin
        pend_d[sel][core] = 1'b1;
      end
    end else if (wr) begin
      if (mine && found) begin
        holder_d[sel]    = nxt;
        pend_d[sel][nxt] = 1'b0;
      end else if (mine) begin
        held_d[sel] = 1'b0;
      end else if (waiting) begin
        pend_d[sel][core] = 1'b0;
      end
    end
    if (rd) data_d = {14'b0, waiting, mine};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q <= '0;
      data_q <= '0;
      for (int i = 0; i < NUM_LOCKS; i++) begin
        holder_q[i] <= '0;
        pend_q[i]   <= '0;
      end
    end else begin
      held_q   <= held_d;
      data_q   <= data_d;
      holder_q <= holder_d;
      pend_q   <= pend_d;
    end
  end
endmodule

// File: tb/tb_device_lock_arbiter.sv
// tb_device_lock_arbiter: directed acquire/queue/hand-off/reset sequence with immediate-assertion checks
module tb_device_lock_arbiter;
  logic       clk;
  logic       reset;
  logic [3:0] lock_held;
  int         checks = 0;
  int         errors = 0;
  device_lock_arbiter_if #(.NUM_CORES(16)) bus ();
  device_lock_arbiter #(.NUM_CORES(16), .NUM_LOCKS(4), .BASE_ADDR(10'h3f0)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .lock_held (lock_held)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic op(input int core, input logic we, input logic re, input logic [9:0] addr, input logic [15:0] d);
    bus.device_core_id  = 4'(core);
    bus.device_write_en = we;
    bus.device_read_en  = re;
    bus.device_addr     = addr;
    bus.device_data_out = d;
    @(posedge clk);
    #1;
    bus.device_write_en = 1'b0;
    bus.device_read_en  = 1'b0;
  endtask
  task automatic acq(input int core, input logic [9:0] addr);
    op(core, 1'b1, 1'b0, addr, 16'h0001);
  endtask
  task automatic rel(input int core, input logic [9:0] addr);
    op(core, 1'b1, 1'b0, addr, 16'h0000);
  endtask
  task automatic rd(input int core, input logic [9:0] addr);
    op(core, 1'b0, 1'b1, addr, 16'h0000);
  endtask
  initial begin
    reset = 1'b1;
    bus.device_core_id  = '0;
    bus.device_write_en = 1'b0;
    bus.device_read_en  = 1'b0;
    bus.device_addr     = '0;
    bus.device_data_out = '0;
    #3;
    chk("rst_lock_held", 16'(lock_held), 16'h0000);
    chk("rst_data_in", bus.device_data_in, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    acq(3, 10'h3f0);
    rd(3, 10'h3f0);
    chk("own_read_c3", bus.device_data_in, 16'h0001);
    rd(5, 10'h3f0);
    chk("other_read_c5", bus.device_data_in, 16'h0000);
    chk("held_l0", 16'(lock_held), 16'h0001);
    acq(7, 10'h3f0);
    acq(1, 10'h3f0);
    rd(7, 10'h3f0);
    chk("pend_c7", bus.device_data_in, 16'h0002);
    rd(1, 10'h3f0);
    chk("pend_c1", bus.device_data_in, 16'h0002);
    rel(3, 10'h3f0);
    chk("handoff_held", 16'(lock_held), 16'h0001);
    rd(7, 10'h3f0);
    chk("handoff_c7", bus.device_data_in, 16'h0001);
    rd(1, 10'h3f0);
    chk("still_pend_c1", bus.device_data_in, 16'h0002);
    rel(7, 10'h3f0);
    rd(1, 10'h3f0);
    chk("handoff_c1", bus.device_data_in, 16'h0001);
    rel(1, 10'h3f0);
    chk("free_l0", 16'(lock_held), 16'h0000);
    acq(14, 10'h3f1);
    acq(2, 10'h3f1);
    acq(15, 10'h3f1);
    rel(14, 10'h3f1);
    rd(15, 10'h3f1);
    chk("wrap_c15", bus.device_data_in, 16'h0001);
    rd(2, 10'h3f1);
    chk("wrap_pend_c2", bus.device_data_in, 16'h0002);
    rel(15, 10'h3f1);
    rd(2, 10'h3f1);
    chk("wrap_c2", bus.device_data_in, 16'h0001);
    rel(2, 10'h3f1);
    chk("free_l1", 16'(lock_held), 16'h0000);
    acq(4, 10'h3f3);
    acq(6, 10'h3f3);
    acq(8, 10'h3f3);
    rel(9, 10'h3f3);
    rd(4, 10'h3f3);
    chk("stray_rel_c4", bus.device_data_in, 16'h0001);
    rd(9, 10'h3f3);
    chk("stray_rel_c9", bus.device_data_in, 16'h0000);
    rel(6, 10'h3f3);
    rd(6, 10'h3f3);
    chk("cancel_c6", bus.device_data_in, 16'h0000);
    rel(4, 10'h3f3);
    rd(8, 10'h3f3);
    chk("skip_to_c8", bus.device_data_in, 16'h0001);
    rd(6, 10'h3f3);
    chk("skipped_c6", bus.device_data_in, 16'h0000);
    chk("held_l3", 16'(lock_held), 16'h0008);
    rel(8, 10'h3f3);
    chk("free_l3", 16'(lock_held), 16'h0000);
    acq(5, 10'h3f2);
    rd(5, 10'h3f2);
    chk("own_read_c5", bus.device_data_in, 16'h0001);
    op(5, 1'b1, 1'b1, 10'h3f2, 16'h0000);
    chk("rw_free_l2", 16'(lock_held), 16'h0000);
    chk("rw_data_kept", bus.device_data_in, 16'h0001);
    acq(0, 10'h3f4);
    chk("miss_above", 16'(lock_held), 16'h0000);
    rd(0, 10'h3f4);
    chk("miss_rd_above", bus.device_data_in, 16'h0001);
    rd(0, 10'h3ef);
    chk("miss_rd_below", bus.device_data_in, 16'h0001);
    acq(10, 10'h3f2);
    acq(11, 10'h3f2);
    acq(12, 10'h3f2);
    rd(11, 10'h3f2);
    chk("pre_rst_c11", bus.device_data_in, 16'h0002);
    chk("pre_rst_held", 16'(lock_held), 16'h0004);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_held", 16'(lock_held), 16'h0000);
    chk("async_rst_data", bus.device_data_in, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    acq(11, 10'h3f2);
    rd(11, 10'h3f2);
    chk("post_rst_c11", bus.device_data_in, 16'h0001);
    rd(10, 10'h3f2);
    chk("post_rst_c10", bus.device_data_in, 16'h0000);
    rd(12, 10'h3f2);
    chk("post_rst_c12", bus.device_data_in, 16'h0000);
    chk("post_rst_held", 16'(lock_held), 16'h0004);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
